// File: rtl/serial_timer.sv
// Serial-load countdown timer with tick prescaler, abort and result/ready handshake.
// Optional periodic reload on acknowledge is enabled by defining SERIAL_TIMER_RELOAD_EN.
module serial_timer #(
  parameter int WIDTH   = 32,
  parameter int DIV_CNT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start_req_i,
  input  logic             start_data_i,
  input  logic             abort_i,
  input  logic             ready_i,
`ifdef SERIAL_TIMER_RELOAD_EN
  input  logic             reload_i,
`endif
  output logic             result_rsp_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] count_o
);

  localparam int PW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_CNT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [PW-1:0]    presc, presc_nx;
`ifdef SERIAL_TIMER_RELOAD_EN
  logic [WIDTH-1:0] rld, rld_nx;
`endif

  // A low enable freezes every register; reset still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      presc <= '0;
`ifdef SERIAL_TIMER_RELOAD_EN
      rld   <= '0;
`endif
    end else if (en) begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      presc <= presc_nx;
`ifdef SERIAL_TIMER_RELOAD_EN
      rld   <= rld_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    presc_nx = presc;
`ifdef SERIAL_TIMER_RELOAD_EN
    rld_nx   = rld;
`endif
    if (abort_i && state != IDLE) begin
      state_nx = IDLE;
      sr_nx    = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req_i) begin
            sr_nx    = {{(WIDTH-1){1'b0}}, start_data_i};
            state_nx = LOAD;
          end
        end
        LOAD: begin
          if (start_req_i) begin
            sr_nx = {sr[WIDTH-2:0], start_data_i};
          end else begin
            cnt_nx   = sr;
            presc_nx = '0;
`ifdef SERIAL_TIMER_RELOAD_EN
            rld_nx   = sr;
`endif
            state_nx = (sr != '0) ? COUNT : DONE;
          end
        end
        COUNT: begin
          if (presc == PRESC_MAX) begin
            presc_nx = '0;
            if (cnt != '0) begin
              cnt_nx = cnt - 1'b1;
            end
            // Reaching zero on this tick completes the countdown.
            if (cnt <= WIDTH'(1)) begin
              state_nx = DONE;
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
`ifdef SERIAL_TIMER_RELOAD_EN
            if (reload_i) begin
              cnt_nx   = rld;
              presc_nx = '0;
              state_nx = (rld != '0) ? COUNT : DONE;
            end else begin
              state_nx = IDLE;
            end
`else
            state_nx = IDLE;
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign result_rsp_o = (state == DONE);
  assign count_o      = cnt;

endmodule

// File: tb/tb_serial_timer.sv
// Randomised self-checking bench for serial_timer (WIDTH=8, DIV_CNT=4) against a timing model
// derived from loaded value and elapsed enabled cycles; also covers SERIAL_TIMER_RELOAD_EN builds.
module tb_serial_timer;

  localparam int WIDTH   = 8;
  localparam int DIV_CNT = 4;
  localparam int GUARD   = 4000;

  logic             clk = 1'b0;
  logic             rst, en, start_req_i, start_data_i, abort_i, ready_i;
`ifdef SERIAL_TIMER_RELOAD_EN
  logic             reload_i;
`endif
  logic             result_rsp_o, busy_o;
  logic [WIDTH-1:0] count_o;

  int nCompared   = 0;
  int nMismatched = 0;

  serial_timer #(.WIDTH(WIDTH), .DIV_CNT(DIV_CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start_req_i  (start_req_i),
    .start_data_i (start_data_i),
    .abort_i      (abort_i),
    .ready_i      (ready_i),
`ifdef SERIAL_TIMER_RELOAD_EN
    .reload_i     (reload_i),
`endif
    .result_rsp_o (result_rsp_o),
    .busy_o       (busy_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int expCount, input int expBusy, input int expResult);
    checkOutput({tag, ".count"}, 32'(count_o), 32'(expCount));
    checkOutput({tag, ".busy"}, 32'(busy_o), 32'(expBusy));
    checkOutput({tag, ".result"}, 32'(result_rsp_o), 32'(expResult));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Countdown phase: remaining count is v minus completed DIV_CNT-cycle periods of enabled time.
  task automatic countPhase(input int v, input int abortAt, input int useReset, input int freezeStart,
                            input int freezeLen, input int randFreeze, input logic earlyReady,
                            output int aborted);
    int t, c, target;
    t = 0; c = 0; target = v * DIV_CNT; aborted = 0;
    while (t < target && c < GUARD && aborted == 0) begin
      en = 1'b1; abort_i = 1'b0; rst = 1'b0; ready_i = earlyReady;
      if (randFreeze != 0 && $urandom_range(0, 4) == 0) en = 1'b0;
      if (freezeLen > 0 && c >= freezeStart && c < freezeStart + freezeLen) en = 1'b0;
      if (abortAt >= 0 && en && (t % DIV_CNT) == 0 && (v - t / DIV_CNT) == abortAt) begin
        if (useReset != 0) rst = 1'b1; else abort_i = 1'b1;
        stepCycle();
        rst = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
        checkAll("abort", 0, 0, 0);
        stepCycle();
        checkAll("post_abort", 0, 0, 0);
        aborted = 1;
      end else begin
        stepCycle();
        c++;
        if (en) t++;
        checkAll("count", v - t / DIV_CNT, 1, (t >= target) ? 1 : 0);
      end
    end
    if (c >= GUARD) checkOutput("timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] bits, input int k, input int abortAt, input int useReset,
                               input int freezeStart, input int freezeLen, input int randFreeze,
                               input int doReload);
    int v, aborted, waits;
    logic earlyReady;
    v = 0;
    abort_i = 1'b0; ready_i = 1'b0; en = 1'b1;
`ifdef SERIAL_TIMER_RELOAD_EN
    reload_i = 1'b0;
`endif
    for (int i = k - 1; i >= 0; i--) begin
      start_req_i  = 1'b1;
      start_data_i = bits[i];
      stepCycle();
      v = ((v << 1) | int'(bits[i])) & ((1 << WIDTH) - 1);
      checkOutput("load.busy", 32'(busy_o), 32'd1);
      checkOutput("load.result", 32'(result_rsp_o), 32'd0);
    end
    start_req_i  = 1'b0;
    start_data_i = 1'($urandom);
    stepCycle();
    checkAll("entry", v, 1, (v == 0) ? 1 : 0);

    earlyReady = ($urandom_range(0, 3) == 0);
    countPhase(v, abortAt, useReset, freezeStart, freezeLen, randFreeze, earlyReady, aborted);
    if (aborted != 0) return;

    if (!earlyReady) begin
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        en = $urandom_range(0, 1) == 1;
        ready_i = !en;
        stepCycle();
        checkAll("done_hold", 0, 1, 1);
      end
    end

`ifdef SERIAL_TIMER_RELOAD_EN
    if (doReload != 0) begin
      en = 1'b1; ready_i = 1'b1; reload_i = 1'b1;
      stepCycle();
      ready_i = 1'b0; reload_i = 1'b0;
      checkAll("reload", v, 1, (v == 0) ? 1 : 0);
      countPhase(v, -1, 0, 0, 0, 0, 1'b0, aborted);
    end
`endif

    en = 1'b1; ready_i = 1'b1;
    stepCycle();
    ready_i = 1'b0;
    checkAll("ack", 0, 0, 0);
  endtask

  initial begin
    logic [15:0] rbits;
    int          rk, rAbort;
    rst = 1'b1; en = 1'b1; start_req_i = 1'b0; start_data_i = 1'b0;
    abort_i = 1'b0; ready_i = 1'b0;
`ifdef SERIAL_TIMER_RELOAD_EN
    reload_i = 1'b0;
`endif
    stepCycle();
    stepCycle();
    checkAll("reset", 0, 0, 0);
    rst = 1'b0;
    stepCycle();
    checkAll("idle", 0, 0, 0);

    applyStimulus(16'b0000000000000101, 8, -1, 0, 0, 0, 0, 0);
    applyStimulus(16'b0000001100000011, 10, -1, 0, 0, 0, 0, 0);
    applyStimulus(16'b0000000000000000, 8, -1, 0, 0, 0, 0, 0);
    applyStimulus(16'b0000000000000101, 8, 2, 0, 0, 0, 0, 0);
    applyStimulus(16'b0000000000000101, 8, 2, 1, 0, 0, 0, 0);
    applyStimulus(16'b0000000000000101, 8, -1, 0, 6, 10, 0, 0);
    applyStimulus(16'b0000000000000101, 8, -1, 0, 0, 0, 0, 1);

    abort_i = 1'b1;
    stepCycle();
    abort_i = 1'b0;
    checkAll("idle_abort", 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      rbits  = 16'($urandom);
      rk     = $urandom_range(1, 12);
      rAbort = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : -1;
      applyStimulus(rbits, rk, rAbort, $urandom_range(0, 1), 0, 0, 1, $urandom_range(0, 1));
      stepCycle();
      checkAll("gap", 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
